// File: rtl/bsg_dmc_pkg.sv
// Shared DMC user-interface definitions.
//   app_cmd_e     : 3-bit app_cmd encoding driven onto the DMC UI
//   arb_state_e   : UI arbiter state (command arbitration / write burst)
//   is_write_cmd  : true for commands that carry a write-data burst
//   is_read_cmd   : true for commands that return read beats
package bsg_dmc_pkg;

  typedef enum logic [2:0] {
    WR  = 3'b000,
    RD  = 3'b001,
    WP  = 3'b010,
    RP  = 3'b011,
    PRE = 3'b100,
    REF = 3'b101
  } app_cmd_e;

  typedef enum logic {
    ARB   = 1'b0,
    WDATA = 1'b1
  } arb_state_e;

  function automatic logic is_write_cmd(app_cmd_e c);
    return (c == WR) || (c == WP);
  endfunction

  function automatic logic is_read_cmd(app_cmd_e c);
    return (c == RD) || (c == RP);
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear, wrapping to 0 after max_val_p.
//   clk_i, reset_i : clock, synchronous active-high reset (count -> 0)
//   clear_i        : zero the count (an up_i in the same cycle yields 1)
//   up_i           : increment
//   count_o        : current count
module bsg_counter_clear_up #(
  parameter int max_val_p = 1,
  localparam int width_lp = (max_val_p > 0) ? $clog2(max_val_p + 1) : 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_o <= '0;
    else if (clear_i)
      count_o <= up_i ? width_lp'(1) : '0;
    else if (up_i)
      count_o <= (count_o == width_lp'(max_val_p)) ? '0 : count_o + width_lp'(1);
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO, one write and one read port, valid/ready in and
// valid/yumi out. The caller must only push when ready_o is high.
//   clk_i, reset_i : clock, synchronous active-high reset
//   v_i, data_i    : push request and data
//   ready_o        : not full
//   v_o, data_o    : head valid and head data
//   yumi_i         : pop the head
module bsg_fifo_1r1w_small #(
  parameter int els_p   = 8,
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                push, pop;

  assign ready_o = (count_r != cnt_w_lp'(els_p));
  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rd_ptr_r];
  // full blocks a push even when a pop lands in the same cycle
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push, pop})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_r[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_dmc_ui_arbiter.sv
// Round-robin arbiter sharing one DMC app_* user interface among
// num_req_p requesters. Commands are serialised; a write command locks the
// write-data channel to its requester for a whole burst; read beats are
// routed back to their issuer in command order via an owner-ID FIFO.
//   core_clk_i, core_reset_i      : clock, synchronous active-high reset
//   req_v/cmd/addr_i, req_yumi_o  : per-requester command channel
//   req_wdata_v/wdata/wmask_i,
//   req_wdata_yumi_o              : per-requester write-beat channel
//   rd_data_o, rd_v_o             : shared read data, one-hot read valid
//   app_*                         : DMC user interface
module bsg_dmc_ui_arbiter
  import bsg_dmc_pkg::*;
#(
  parameter int num_req_p     = 2,
  parameter int addr_width_p  = 28,
  parameter int data_width_p  = 32,
  parameter int burst_width_p = 2,
  parameter int rd_fifo_els_p = 8,
  localparam int mask_w_lp    = data_width_p >> 3,
  localparam int id_w_lp      = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                     core_clk_i,
  input  logic                                     core_reset_i,

  input  logic [num_req_p-1:0]                     req_v_i,
  input  logic [num_req_p-1:0][2:0]                req_cmd_i,
  input  logic [num_req_p-1:0][addr_width_p-1:0]   req_addr_i,
  output logic [num_req_p-1:0]                     req_yumi_o,

  input  logic [num_req_p-1:0]                     req_wdata_v_i,
  input  logic [num_req_p-1:0][data_width_p-1:0]   req_wdata_i,
  input  logic [num_req_p-1:0][mask_w_lp-1:0]      req_wmask_i,
  output logic [num_req_p-1:0]                     req_wdata_yumi_o,

  output logic [data_width_p-1:0]                  rd_data_o,
  output logic [num_req_p-1:0]                     rd_v_o,

  output logic [addr_width_p-1:0]                  app_addr_o,
  output logic [2:0]                               app_cmd_o,
  output logic                                     app_en_o,
  input  logic                                     app_rdy_i,
  output logic                                     app_wdf_wren_o,
  output logic [data_width_p-1:0]                  app_wdf_data_o,
  output logic [mask_w_lp-1:0]                     app_wdf_mask_o,
  output logic                                     app_wdf_end_o,
  input  logic                                     app_wdf_rdy_i,
  input  logic                                     app_rd_data_valid_i,
  input  logic [data_width_p-1:0]                  app_rd_data_i,
  input  logic                                     app_rd_data_end_i
);

  localparam int beat_max_lp = burst_width_p - 1;
  localparam int beat_w_lp   = (beat_max_lp > 0) ? $clog2(beat_max_lp + 1) : 1;

  arb_state_e           state_r, state_n;
  logic [id_w_lp-1:0]   rr_ptr_r, owner_r, winner;
  logic                 winner_v;
  logic [num_req_p-1:0] eligible;
  logic                 fifo_ready, fifo_v;
  logic [id_w_lp-1:0]   fifo_head;
  logic [beat_w_lp-1:0] beat_cnt;
  logic                 accept, win_is_wr, win_is_rd, beat_go, last_beat;

  // a full owner FIFO masks readers only; writers keep competing
  for (genvar i = 0; i < num_req_p; i++) begin : g_elig
    assign eligible[i] = req_v_i[i]
                       & (~is_read_cmd(app_cmd_e'(req_cmd_i[i])) | fifo_ready);
  end

  // first eligible requester at or after rr_ptr_r; scanning offsets from
  // the top down leaves the smallest hit in winner
  always_comb begin
    int idx;
    idx      = 0;
    winner   = '0;
    winner_v = 1'b0;
    for (int off = num_req_p - 1; off >= 0; off--) begin
      idx = (int'(rr_ptr_r) + off) % num_req_p;
      if (eligible[idx]) begin
        winner   = id_w_lp'(idx);
        winner_v = 1'b1;
      end
    end
  end

  assign win_is_wr  = is_write_cmd(app_cmd_e'(req_cmd_i[winner]));
  assign win_is_rd  = is_read_cmd(app_cmd_e'(req_cmd_i[winner]));

  assign app_en_o   = (state_r == ARB) & winner_v & ~core_reset_i;
  assign app_cmd_o  = req_cmd_i[winner];
  assign app_addr_o = req_addr_i[winner];
  assign accept     = app_en_o & app_rdy_i;

  always_comb begin
    req_yumi_o = '0;
    if (accept) req_yumi_o[winner] = 1'b1;
  end

  // write-data channel, locked to owner_r for the burst
  assign app_wdf_wren_o = (state_r == WDATA) & req_wdata_v_i[owner_r] & ~core_reset_i;
  assign app_wdf_data_o = req_wdata_i[owner_r];
  assign app_wdf_mask_o = req_wmask_i[owner_r];
  assign last_beat      = (beat_cnt == beat_w_lp'(beat_max_lp));
  assign app_wdf_end_o  = app_wdf_wren_o & last_beat;
  assign beat_go        = app_wdf_wren_o & app_wdf_rdy_i;

  always_comb begin
    req_wdata_yumi_o = '0;
    if (beat_go) req_wdata_yumi_o[owner_r] = 1'b1;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      ARB:     if (accept & win_is_wr)   state_n = WDATA;
      WDATA:   if (beat_go & last_beat)  state_n = ARB;
      default: state_n = ARB;
    endcase
  end

  always_ff @(posedge core_clk_i) begin
    if (core_reset_i) begin
      state_r  <= ARB;
      rr_ptr_r <= '0;
      owner_r  <= '0;
    end else begin
      state_r <= state_n;
      if (accept)
        rr_ptr_r <= (winner == id_w_lp'(num_req_p - 1)) ? '0 : winner + id_w_lp'(1);
      if (accept & win_is_wr)
        owner_r <= winner;
    end
  end

  bsg_counter_clear_up #(
    .max_val_p(beat_max_lp)
  ) beat_counter (
    .clk_i   (core_clk_i),
    .reset_i (core_reset_i),
    .clear_i (accept & win_is_wr),
    .up_i    (beat_go),
    .count_o (beat_cnt)
  );

  // read return: purely combinational routing by FIFO head
  bsg_fifo_1r1w_small #(
    .els_p   (rd_fifo_els_p),
    .width_p (id_w_lp)
  ) owner_fifo (
    .clk_i   (core_clk_i),
    .reset_i (core_reset_i),
    .v_i     (accept & win_is_rd),
    .data_i  (winner),
    .ready_o (fifo_ready),
    .v_o     (fifo_v),
    .data_o  (fifo_head),
    .yumi_i  (app_rd_data_valid_i & app_rd_data_end_i & ~core_reset_i)
  );

  assign rd_data_o = app_rd_data_i;

  always_comb begin
    rd_v_o = '0;
    if (app_rd_data_valid_i & fifo_v & ~core_reset_i) rd_v_o[fifo_head] = 1'b1;
  end

  // a read beat with no outstanding read is dropped; flag it in simulation
  always_ff @(posedge core_clk_i) begin
    if (!core_reset_i)
      assert (!(app_rd_data_valid_i && !fifo_v))
        else $warning("bsg_dmc_ui_arbiter: read beat with no outstanding read dropped");
  end

endmodule

// File: tb/tb_bsg_dmc_ui_arbiter.sv
module tb_bsg_dmc_ui_arbiter;
  import bsg_dmc_pkg::*;

  localparam int N  = 2;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int MW = DW >> 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [N-1:0]          req_v, req_yumi, wv, wy, rd_v;
  logic [N-1:0][2:0]     req_cmd;
  logic [N-1:0][AW-1:0]  req_addr;
  logic [N-1:0][DW-1:0]  wd;
  logic [N-1:0][MW-1:0]  wm;
  logic [DW-1:0]         rd_data, wdf_data, rdd;
  logic [AW-1:0]         app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en, app_rdy, wren, wdf_end, wdf_rdy, rdv, rde;
  logic [MW-1:0]         wdf_mask;

  int npass = 0;
  int total = 0;

  bsg_dmc_ui_arbiter #(
    .num_req_p(N), .addr_width_p(AW), .data_width_p(DW),
    .burst_width_p(2), .rd_fifo_els_p(2)
  ) dut (
    .core_clk_i(clk), .core_reset_i(rst),
    .req_v_i(req_v), .req_cmd_i(req_cmd), .req_addr_i(req_addr), .req_yumi_o(req_yumi),
    .req_wdata_v_i(wv), .req_wdata_i(wd), .req_wmask_i(wm), .req_wdata_yumi_o(wy),
    .rd_data_o(rd_data), .rd_v_o(rd_v),
    .app_addr_o(app_addr), .app_cmd_o(app_cmd), .app_en_o(app_en), .app_rdy_i(app_rdy),
    .app_wdf_wren_o(wren), .app_wdf_data_o(wdf_data), .app_wdf_mask_o(wdf_mask),
    .app_wdf_end_o(wdf_end), .app_wdf_rdy_i(wdf_rdy),
    .app_rd_data_valid_i(rdv), .app_rd_data_i(rdd), .app_rd_data_end_i(rde)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_v = '0; req_cmd = '0; req_addr = '0; wv = '0; wd = '0; wm = '0;
    app_rdy = 1'b1; wdf_rdy = 1'b1; rdv = 1'b0; rdd = '0; rde = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_app_en", app_en, 0);
    chk("rst_yumi", req_yumi, 0);
    chk("rst_wren", wren, 0);
    chk("rst_end", wdf_end, 0);
    chk("rst_rd_v", rd_v, 0);
    chk("rst_wyumi", wy, 0);

    // both requesters read; fifo depth 2 fills after two accepts
    req_v = 2'b11; req_cmd[0] = RD; req_cmd[1] = RD;
    req_addr[0] = 28'h100; req_addr[1] = 28'h200;
    #1;
    chk("rd0_app_en", app_en, 1);
    chk("rd0_yumi", req_yumi, 2'b01);
    chk("rd0_addr", app_addr, 28'h100);
    chk("rd0_cmd", app_cmd, RD);
    nxt(); #1;
    chk("rd1_yumi", req_yumi, 2'b10);
    chk("rd1_addr", app_addr, 28'h200);
    nxt(); #1;
    chk("rdfull_yumi", req_yumi, 2'b00);
    chk("rdfull_app_en", app_en, 0);

    // two-beat returns, end on every second beat
    req_v = '0; rdv = 1'b1; rdd = 32'hD000_0000; rde = 1'b0; #1;
    chk("ret0_v", rd_v, 2'b01);
    chk("ret0_data", rd_data, 32'hD000_0000);
    nxt(); rdd = 32'hD000_0001; rde = 1'b1; #1;
    chk("ret1_v", rd_v, 2'b01);
    nxt(); rdd = 32'hD000_0002; rde = 1'b0; #1;
    chk("ret2_v", rd_v, 2'b10);
    nxt(); rdd = 32'hD000_0003; rde = 1'b1; #1;
    chk("ret3_v", rd_v, 2'b10);
    chk("ret3_data", rd_data, 32'hD000_0003);
    // stray beat with nothing outstanding is dropped
    nxt(); rdd = 32'hDEAD_BEEF; #1;
    chk("empty_rd_v", rd_v, 2'b00);
    chk("empty_rd_data", rd_data, 32'hDEAD_BEEF);
    nxt(); rdv = 1'b0; rde = 1'b0;

    // write burst from req0 blocks req1's read until after the last beat
    req_v = 2'b11; req_cmd[0] = WR; req_addr[0] = 28'h40;
    req_cmd[1] = RD; req_addr[1] = 28'h300;
    wv = 2'b01; wd[0] = 32'hAAAA_0001; wm[0] = 4'h0; #1;
    chk("wr_yumi", req_yumi, 2'b01);
    chk("wr_cmd", app_cmd, WR);
    chk("wr_addr", app_addr, 28'h40);
    chk("wr_acc_wren", wren, 0);
    nxt(); req_v = 2'b10; #1;
    chk("b0_app_en", app_en, 0);
    chk("b0_yumi", req_yumi, 2'b00);
    chk("b0_wren", wren, 1);
    chk("b0_data", wdf_data, 32'hAAAA_0001);
    chk("b0_end", wdf_end, 0);
    chk("b0_wyumi", wy, 2'b01);
    nxt(); wd[0] = 32'hAAAA_0002; wm[0] = 4'h3; #1;
    chk("b1_yumi", req_yumi, 2'b00);
    chk("b1_data", wdf_data, 32'hAAAA_0002);
    chk("b1_mask", wdf_mask, 4'h3);
    chk("b1_end", wdf_end, 1);
    chk("b1_wyumi", wy, 2'b01);
    nxt(); wv = '0; #1;
    chk("post_wr_yumi", req_yumi, 2'b10);
    chk("post_wr_addr", app_addr, 28'h300);
    chk("post_wr_wren", wren, 0);
    nxt(); req_v = '0;

    // write-data stall: beat held, end only on the second beat
    req_v = 2'b01; req_cmd[0] = WR; req_addr[0] = 28'h80;
    wv = 2'b01; wd[0] = 32'hBBBB_0001; #1;
    chk("st_yumi", req_yumi, 2'b01);
    nxt(); req_v = '0; #1;
    chk("st0_wyumi", wy, 2'b01);
    chk("st0_end", wdf_end, 0);
    nxt(); wd[0] = 32'hBBBB_0002; wdf_rdy = 1'b0; #1;
    chk("stall_wren", wren, 1);
    chk("stall_wyumi", wy, 2'b00);
    chk("stall_end", wdf_end, 1);
    nxt(); wdf_rdy = 1'b1; #1;
    chk("st1_wyumi", wy, 2'b01);
    chk("st1_data", wdf_data, 32'hBBBB_0002);
    chk("st1_end", wdf_end, 1);
    nxt(); wv = '0;

    // pop of req1's earlier read alongside a new push from req1
    req_v = 2'b10; req_cmd[1] = RD; req_addr[1] = 28'h400; rdv = 1'b1; rde = 1'b1; #1;
    chk("pp_rd_v", rd_v, 2'b10);
    chk("pp_yumi", req_yumi, 2'b10);
    nxt(); rdv = 1'b0; rde = 1'b0; req_addr[1] = 28'h404; #1;
    chk("fill_yumi", req_yumi, 2'b10);
    nxt(); #1;
    chk("full_rd_yumi", req_yumi, 2'b00);
    // fifo full: read masked, write from req0 still wins
    req_v = 2'b11; req_cmd[0] = WR; req_addr[0] = 28'hC0; wv = 2'b01; wd[0] = 32'hCCCC_0001; #1;
    chk("full_wr_yumi", req_yumi, 2'b01);
    chk("full_wr_cmd", app_cmd, WR);
    nxt(); req_v = 2'b10; #1;
    chk("full_b0_wyumi", wy, 2'b01);

    // reset after one beat abandons the burst
    nxt(); rst = 1'b1; req_v = '0;
    nxt(); rst = 1'b0; #1;
    chk("rst2_wren", wren, 0);
    chk("rst2_end", wdf_end, 0);
    chk("rst2_wyumi", wy, 0);
    chk("rst2_app_en", app_en, 0);
    req_v = 2'b11; req_cmd[0] = RD; req_cmd[1] = RD; #1;
    chk("rst2_rr_yumi", req_yumi, 2'b01);
    nxt(); req_v = '0; wv = '0;

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

endmodule
